// File: rtl/dp_result_fifo.sv
// Result capture FIFO for a generated datapath.
// Buffers {x, z} result pairs and drains them through a valid/ready handshake.
// Full/empty are decided from the occupancy counter, never from the pointers.
// A word offered while full is dropped and latched into the sticky overflow flag.
module dp_result_fifo #(
  parameter int unsigned XW    = 16,
  parameter int unsigned ZW    = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          in_valid,
  input  logic [XW-1:0] x,
  input  logic [ZW-1:0] z,
  output logic          in_ready,
  output logic          out_valid,
  output logic [XW-1:0] out_x,
  output logic [ZW-1:0] out_z,
  input  logic          out_ready,
  output logic [AW:0]   count,
  output logic          overflow,
  input  logic          clr_ovf
);

  logic [XW-1:0] r_mem_x [DEPTH];
  logic [ZW-1:0] r_mem_z [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_overflow;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_drop;

  // Handshake decode; in_ready depends only on the registered count.
  always_comb begin
    w_full  = (r_count == (AW+1)'(DEPTH));
    w_empty = (r_count == '0);
    w_push  = in_valid & ~w_full;
    w_pop   = ~w_empty & out_ready;
    w_drop  = in_valid & w_full;
  end

  assign in_ready  = ~w_full;
  assign out_valid = ~w_empty;
  assign out_x     = r_mem_x[r_rd_ptr];
  assign out_z     = r_mem_z[r_rd_ptr];
  assign count     = r_count;
  assign overflow  = r_overflow;

  // Storage write; reset clears every entry so the head reads 0 afterwards.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem_x[i] <= '0;
        r_mem_z[i] <= '0;
      end
    end else if (w_push) begin
      r_mem_x[r_wr_ptr] <= x;
      r_mem_z[r_wr_ptr] <= z;
    end
  end

  // Pointer advance; AW-bit pointers wrap naturally at DEPTH.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
    end
  end

  // Occupancy: simultaneous push and pop leave it unchanged.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow; a new drop takes priority over a clear in the same cycle.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (clr_ovf) begin
      r_overflow <= 1'b0;
    end
  end

endmodule
